nv_nvdla_pdp_pool1d_lanes: RTL
==============================

# nv_nvdla_pdp_pool1d_lanes

Parametrised horizontal (1-D) pooling engine for the PDP datapath, the successor to the fixed single-lane cal1d stage. It consumes one width position per beat, carrying LANES channel elements. It applies left/right padding internally and pools with kernel 1..KMAX and stride 1..16, including overlapping windows (stride < kernel). It emits one result beat per output column, in max, min or sum mode, toward the vertical (2-D) stage.

## Interface
- LANES, 8, channel elements per beat
- DW, 8, signed input element width
- KMAX, 8, maximum kernel width (power of two)
- ODW, DW+$clog2(KMAX), output element width
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset; one clock, reset is synchronous and active-low
- op_start  in  1  pulse; latches all cfg_* and starts an operation
- cfg_width  in  13  input line width minus 1
- cfg_height  in  13  lines per operation minus 1
- cfg_kernel  in  $clog2(KMAX)  kernel width minus 1
- cfg_stride  in  4  stride minus 1
- cfg_pad_left / cfg_pad_right  in  3 each  pad columns; must be ≤ kernel-1
- cfg_pad_value  in  DW  signed pad element
- cfg_mode  in  2  0 sum, 1 max, 2 min, 3 reserved (behaves as sum)
- in_valid / in_ready  in / out  1  input handshake
- in_pd  in  LANES*DW  lane i at bits [i*DW +: DW]
- out_valid / out_ready  out / in  1  output handshake
- out_pd  out  LANES*ODW  pooled results, same lane order
- out_eol  out  1  qualifies the last column of a line
- busy  out  1  operation in progress
- done  out  1  single-cycle completion pulse

## Operation
- Virtual line = pad_left pad positions, then W input positions, then pad_right pad positions. Length V = W+pl+pr.
- Output columns per line: OW = (V-K)/S + 1 (floor division). If V < K, OW = 0. Input is still consumed, nothing is emitted, and the line counts as complete.
- Window o covers virtual positions o*S .. o*S+K-1. At each position v:
  - open window o if v == o*S and o < OW, initialised with the element;
  - fold the element into every open window;
  - close the window ending at v and emit it.
- At most one window closes per position. Positions after the last window's end are consumed and discarded.
- Accumulator ring: KMAX slots, slot index = o mod KMAX. Each slot holds LANES accumulators plus a remaining-count.
- Pad positions are internal cycles. No input is consumed and in_ready is 0; the element value is cfg_pad_value in every lane, in every mode.
- Arithmetic: elements are sign-extended to ODW. Sum has no saturation, since ODW covers KMAX·(2^(DW-1)). Max and min compare signed values.
- State machine:
  - IDLE → RUN on op_start; op_start is ignored when not IDLE.
  - RUN steps through the virtual positions of each line. It wraps the column counter at V-1 and increments the line counter.
  - After the final position of line cfg_height: RUN → DRAIN, waiting for the last output handshake, then → IDLE with done=1 for one cycle.
- cfg_* are sampled only at op_start. Later changes have no effect until the next op.

## Timing
- Reset values: out_valid=0, out_pd=0, out_eol=0, busy=0, done=0, in_ready=0. All slots and counters are cleared.
- Reset mid-operation aborts immediately. The partial line is lost and no done is issued.
- Throughput: one virtual position per cycle when unstalled.
- Output is registered. out_valid rises the cycle after the closing position is accepted (input beat or pad cycle).
- Stall: out_valid & !out_ready freezes position advance, so in_ready=0 and no pad cycles run. out_pd and out_eol are held stable.
- The output register is refilled in the same cycle its contents handshake, so there is no bubble.
- in_ready = busy & (current position is a real input position) & !stall. in_valid may toggle freely; the absence of valid advances nothing.
- busy rises the cycle after op_start and falls in the same cycle done pulses.

## Structure
- Package nv_nvdla_pdp_pool_pkg:
  - mode constants (SUM, MAX, MIN);
  - the ODW width function;
  - the state enum (IDLE, RUN, DRAIN).
- Sub-module nv_nvdla_pdp_pool1d_fold: combinational single-lane fold(acc, elem, mode, init). It is instantiated LANES×KMAX times.
- The top level holds the counters, the slot ring, the FSM and the output register.

## Test plan
- Max, W=6, K=3, S=1, no pad, lane0 = 1,5,2,7,3,0 → out 5,7,7,7; out_eol on the 4th; done one cycle after the 4th handshake.
- Sum, W=5, K=3, S=2, pl=pr=1, pad=-1, lane0 = 1..5 → out 2,9,8. in_ready is low on the two pad cycles.
- Min, W=7, K=2, S=3, lane0 = 4,2,9,1,6,0,-5 → out 2,1 only. Positions 5 and 6 are consumed with no output.
- Backpressure: scenario 1 with out_ready low for 5 cycles after the first output → in_ready low throughout, output held, identical result stream.
- cfg_height=1 with K=8, S=1, W=8 (all slots live, all LANES distinct) → 1 output per line, 2 lines, single done. An op_start pulsed mid-op is ignored.
- Assert nvdla_core_rstn mid-line, then start a fresh op → all outputs reset to 0; the new op's results match the golden model; no stale slot contribution.

Source files
------------

// File: rtl/nv_nvdla_pdp_pool_pkg.sv
// Shared definitions for the PDP 1-D pooling engine: mode codes, FSM states
// and the output-width helper.
package nv_nvdla_pdp_pool_pkg;

    localparam logic [1:0] SUM = 2'd0;
    localparam logic [1:0] MAX = 2'd1;
    localparam logic [1:0] MIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pool_state_e;

    // A sum of up to kmax signed dw-bit elements fits in dw+log2(kmax) bits.
    function automatic int pool_odw(input int dw, input int kmax);
        return dw + $clog2(kmax);
    endfunction

endpackage

// File: rtl/nv_nvdla_pdp_pool1d_fold.sv
// Single-lane pooling fold: start a window with the element, or merge the
// element into the running accumulator by sum, signed max or signed min.
module nv_nvdla_pdp_pool1d_fold
    import nv_nvdla_pdp_pool_pkg::*;
#(
    parameter int DW  = 8,
    parameter int ODW = 11
) (
    input  logic [ODW-1:0] acc,
    input  logic [DW-1:0]  elem,
    input  logic [1:0]     mode,
    input  logic           init,
    output logic [ODW-1:0] result
);

    logic signed [ODW-1:0] acc_s;
    logic signed [ODW-1:0] elem_s;

    assign acc_s  = acc;
    assign elem_s = {{(ODW-DW){elem[DW-1]}}, elem};

    // Reserved mode 3 falls through to the sum default.
    always_comb begin
        result = acc_s + elem_s;
        if (init) begin
            result = elem_s;
        end else if (mode == MAX) begin
            result = (elem_s > acc_s) ? elem_s : acc_s;
        end else if (mode == MIN) begin
            result = (elem_s < acc_s) ? elem_s : acc_s;
        end
    end

endmodule

// File: rtl/nv_nvdla_pdp_pool1d_lanes.sv
// Multi-lane horizontal pooling engine. Walks the padded virtual line one
// position per cycle, keeps overlapping windows in a KMAX-slot ring and
// emits one registered result beat per closing window.
module nv_nvdla_pdp_pool1d_lanes
    import nv_nvdla_pdp_pool_pkg::*;
#(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int KMAX  = 8,
    parameter int ODW   = pool_odw(DW, KMAX)
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    input  logic                     op_start,
    input  logic [12:0]              cfg_width,
    input  logic [12:0]              cfg_height,
    input  logic [$clog2(KMAX)-1:0]  cfg_kernel,
    input  logic [3:0]               cfg_stride,
    input  logic [2:0]               cfg_pad_left,
    input  logic [2:0]               cfg_pad_right,
    input  logic [DW-1:0]            cfg_pad_value,
    input  logic [1:0]               cfg_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DW-1:0]      in_pd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ODW-1:0]     out_pd,
    output logic                     out_eol,
    output logic                     busy,
    output logic                     done
);

    localparam int KW = $clog2(KMAX);
    // Virtual line length reaches 8192+7+7; one spare bit keeps sums exact.
    localparam int VW = 15;

    pool_state_e state_reg, state_next;

    logic [12:0]    width_reg, height_reg;
    logic [KW-1:0]  kernel_reg;
    logic [3:0]     stride_reg;
    logic [2:0]     pad_left_reg, pad_right_reg;
    logic [DW-1:0]  pad_value_reg;
    logic [1:0]     mode_reg;

    logic [VW-1:0]  col_reg;
    logic [12:0]    line_reg;
    logic [3:0]     phase_reg;
    logic [KW-1:0]  open_idx_reg;

    logic                 out_valid_reg, out_eol_reg, done_reg;
    logic [LANES*ODW-1:0] out_pd_reg;

    logic [VW-1:0] k_len, s_len, w_len, pl_len, v_len;
    logic is_real, stall, running, start_op, step;
    logic do_open, eol_now, line_end, last_line, any_close;

    logic [LANES-1:0][DW-1:0]        elem;
    logic [KMAX-1:0]                 slot_close;
    logic [KMAX-1:0][LANES*ODW-1:0]  slot_pd;
    logic [LANES*ODW-1:0]            close_pd;

    assign k_len  = VW'(kernel_reg) + VW'(1);
    assign s_len  = VW'(stride_reg) + VW'(1);
    assign w_len  = VW'(width_reg) + VW'(1);
    assign pl_len = VW'(pad_left_reg);
    assign v_len  = w_len + pl_len + VW'(pad_right_reg);

    assign running   = (state_reg == RUN);
    assign start_op  = (state_reg == IDLE) && op_start;
    assign stall     = out_valid_reg && !out_ready;
    assign is_real   = (col_reg >= pl_len) && (col_reg < pl_len + w_len);
    assign step      = running && !stall && (!is_real || in_valid);
    assign line_end  = (col_reg == v_len - VW'(1));
    assign last_line = (line_reg == height_reg);
    // A window may open only if it ends inside the virtual line.
    assign do_open   = (phase_reg == 4'd0) && (col_reg + k_len <= v_len);
    // The closing window is the last one when no successor fits the line.
    assign eol_now   = (col_reg + s_len >= v_len);
    assign any_close = |slot_close;

    assign in_ready  = running && is_real && !stall;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign out_valid = out_valid_reg;
    assign out_pd    = out_pd_reg;
    assign out_eol   = out_eol_reg;

    for (genvar gj = 0; gj < LANES; gj++) begin : g_elem
        assign elem[gj] = is_real ? in_pd[gj*DW +: DW] : pad_value_reg;
    end

    for (genvar gi = 0; gi < KMAX; gi++) begin : g_slot
        logic [LANES-1:0][ODW-1:0] acc_reg;
        logic [LANES-1:0][ODW-1:0] folded;
        logic [KW-1:0]             rem_reg;
        logic                      live_reg;
        logic                      open_here, touch, close_here;
        logic [KW-1:0]             rem_after;

        // rem_reg counts elements still owed to the window after those folded.
        assign open_here  = do_open && (open_idx_reg == KW'(gi));
        assign touch      = open_here || live_reg;
        assign rem_after  = open_here ? kernel_reg : rem_reg - KW'(1);
        assign close_here = touch && (rem_after == '0);
        assign slot_close[gi] = close_here;
        assign slot_pd[gi]    = close_here ? folded : '0;

        for (genvar gj = 0; gj < LANES; gj++) begin : g_lane
            nv_nvdla_pdp_pool1d_fold #(
                .DW  (DW),
                .ODW (ODW)
            ) u_fold (
                .acc    (acc_reg[gj]),
                .elem   (elem[gj]),
                .mode   (mode_reg),
                .init   (open_here),
                .result (folded[gj])
            );
        end

        // Slot state: cleared on reset or a new op, updated on each stepped position.
        always_ff @(posedge nvdla_core_clk) begin
            if (!nvdla_core_rstn || start_op) begin
                acc_reg  <= '0;
                rem_reg  <= '0;
                live_reg <= 1'b0;
            end else if (step && touch) begin
                acc_reg  <= folded;
                rem_reg  <= rem_after;
                live_reg <= !close_here;
            end
        end
    end

    // At most one slot closes per position, so OR-ing the masked slots selects it.
    always_comb begin
        close_pd = '0;
        for (int s = 0; s < KMAX; s++) begin
            close_pd = close_pd | slot_pd[s];
        end
    end

    // Configuration capture and position / line / stride-phase counters.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            width_reg     <= '0;
            height_reg    <= '0;
            kernel_reg    <= '0;
            stride_reg    <= '0;
            pad_left_reg  <= '0;
            pad_right_reg <= '0;
            pad_value_reg <= '0;
            mode_reg      <= '0;
            col_reg       <= '0;
            line_reg      <= '0;
            phase_reg     <= '0;
            open_idx_reg  <= '0;
        end else if (start_op) begin
            width_reg     <= cfg_width;
            height_reg    <= cfg_height;
            kernel_reg    <= cfg_kernel;
            stride_reg    <= cfg_stride;
            pad_left_reg  <= cfg_pad_left;
            pad_right_reg <= cfg_pad_right;
            pad_value_reg <= cfg_pad_value;
            mode_reg      <= cfg_mode;
            col_reg       <= '0;
            line_reg      <= '0;
            phase_reg     <= '0;
            open_idx_reg  <= '0;
        end else if (step) begin
            if (line_end) begin
                col_reg      <= '0;
                phase_reg    <= '0;
                open_idx_reg <= '0;
                line_reg     <= line_reg + 13'd1;
            end else begin
                col_reg   <= col_reg + VW'(1);
                phase_reg <= (phase_reg == stride_reg) ? 4'd0 : phase_reg + 4'd1;
                if (do_open) begin
                    open_idx_reg <= open_idx_reg + KW'(1);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: DRAIN waits until the output register is empty or handing off.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (op_start) state_next = RUN;
            RUN:     if (step && line_end && last_line) state_next = DRAIN;
            DRAIN:   if (!out_valid_reg || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output register: refill on a closing step, otherwise drop valid on handshake.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            out_valid_reg <= 1'b0;
            out_pd_reg    <= '0;
            out_eol_reg   <= 1'b0;
        end else if (step && any_close) begin
            out_valid_reg <= 1'b1;
            out_pd_reg    <= close_pd;
            out_eol_reg   <= eol_now;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Completion pulse coincides with busy falling.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == DRAIN) && (state_next == IDLE);
        end
    end

endmodule
